// File: rtl/code_lock_controller_if.sv
// Keypad-side strobes into the lock and the status bundle back out to the display.
interface code_lock_controller_if #(
    parameter int DIGIT_W   = 4,
    parameter int CODE_LEN  = 6,
    parameter int MAX_TRIES = 3
);
    logic [DIGIT_W-1:0]               Digit;
    logic                             Enter;
    logic                             Program;
    logic                             Relock;
    logic                             Open;
    logic                             Alarm;
    logic [2:0]                       StateOut;
    logic [$clog2(CODE_LEN+1)-1:0]    DigitCount;
    logic [$clog2(MAX_TRIES+1)-1:0]   FailCount;

    modport master (
        output Digit, Enter, Program, Relock,
        input  Open, Alarm, StateOut, DigitCount, FailCount
    );

    modport slave (
        input  Digit, Enter, Program, Relock,
        output Open, Alarm, StateOut, DigitCount, FailCount
    );
endinterface

// File: rtl/code_lock_controller.sv
// Digital code lock: absorbs CODE_LEN digits, opens on match, locks out after
// MAX_TRIES misses, and lets the code be rewritten while open.
module code_lock_controller #(
    parameter int                        DIGIT_W        = 4,
    parameter int                        CODE_LEN       = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h110010,
    parameter int                        MAX_TRIES      = 3,
    parameter int                        LOCKOUT_CYCLES = 1000,
    parameter int                        IDLE_TIMEOUT   = 0
) (
    input  logic                   Clock,
    input  logic                   ResetLock,
    code_lock_controller_if.slave  bus
);
    localparam int CW    = CODE_LEN * DIGIT_W;
    localparam int IDX_W = $clog2(CODE_LEN + 1);
    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int IDL_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_TRIES - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_OPEN    = 3'd1,
        S_PROG    = 3'd2,
        S_LOCKOUT = 3'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [FC_W-1:0]    fail_q, fail_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [IDL_W-1:0]   idle_q, idle_d;
    logic [CW-1:0]      code_q, code_d;
    logic [CW-1:0]      shadow_q, shadow_d;
    logic               open_q, alarm_q;
    logic [DIGIT_W-1:0] exp_dig;
    logic [CW-1:0]      shadow_wr;
    logic               miss;

    // Expected digit and the shadow image with the current digit merged in.
    always_comb begin
        exp_dig   = '0;
        shadow_wr = shadow_q;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (idx_q == IDX_W'(k)) begin
                exp_dig = code_q[(CODE_LEN-k)*DIGIT_W-1 -: DIGIT_W];
                shadow_wr[(CODE_LEN-k)*DIGIT_W-1 -: DIGIT_W] = bus.Digit;
            end
        end
    end

    assign miss = mis_q | (bus.Digit != exp_dig);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fail_d   = fail_q;
        tmr_d    = tmr_q;
        idle_d   = idle_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        case (state_q)
            S_ENTRY: begin
                if (bus.Enter) begin
                    idle_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!miss) begin
                            state_d = S_OPEN;
                            fail_d  = '0;
                        end else if (fail_q < FC_LAST) begin
                            fail_d = fail_q + 1'b1;
                        end else begin
                            fail_d  = FC_MAX;
                            state_d = S_LOCKOUT;
                            tmr_d   = TMR_INIT;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        mis_d = miss;
                    end
                end else if (IDLE_TIMEOUT > 0 && idx_q != '0) begin
                    // Abandoned partial entry is silently dropped, not counted as a miss.
                    if (idle_q == IDL_LAST) begin
                        idx_d  = '0;
                        mis_d  = 1'b0;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            S_OPEN: begin
                if (bus.Relock) begin
                    state_d = S_ENTRY;
                end else if (bus.Program) begin
                    state_d = S_PROG;
                    idx_d   = '0;
                end
            end
            S_PROG: begin
                if (bus.Relock) begin
                    state_d = S_ENTRY;
                    idx_d   = '0;
                end else if (bus.Enter) begin
                    shadow_d = shadow_wr;
                    if (idx_q == IDX_LAST) begin
                        code_d  = shadow_wr;
                        state_d = S_OPEN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_d = S_ENTRY;
                    fail_d  = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_ENTRY;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetLock) begin
        if (!ResetLock) begin
            state_q  <= S_ENTRY;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            fail_q   <= '0;
            tmr_q    <= '0;
            idle_q   <= '0;
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
            open_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            fail_q   <= fail_d;
            tmr_q    <= tmr_d;
            idle_q   <= idle_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            open_q   <= (state_d == S_OPEN);
            alarm_q  <= (state_d == S_LOCKOUT);
        end
    end

    assign bus.Open       = open_q;
    assign bus.Alarm      = alarm_q;
    assign bus.StateOut   = state_q;
    assign bus.DigitCount = idx_q;
    assign bus.FailCount  = fail_q;
endmodule

// File: tb/tb_code_lock_controller.sv
// Directed bench for the code lock: main instance without idle timeout,
// second instance with a 50-cycle idle timeout.
module tb_code_lock_controller;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    code_lock_controller_if #(.DIGIT_W(4), .CODE_LEN(6), .MAX_TRIES(3)) bm ();
    code_lock_controller_if #(.DIGIT_W(4), .CODE_LEN(6), .MAX_TRIES(3)) bi ();

    code_lock_controller #(
        .DIGIT_W(4), .CODE_LEN(6), .DEFAULT_CODE(24'h110010),
        .MAX_TRIES(3), .LOCKOUT_CYCLES(1000), .IDLE_TIMEOUT(0)
    ) u_dut (
        .Clock(clk), .ResetLock(rst_n), .bus(bm)
    );

    code_lock_controller #(
        .DIGIT_W(4), .CODE_LEN(6), .DEFAULT_CODE(24'h110010),
        .MAX_TRIES(3), .LOCKOUT_CYCLES(1000), .IDLE_TIMEOUT(50)
    ) u_idle (
        .Clock(clk), .ResetLock(rst_n), .bus(bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_m(input logic [3:0] d);
        bm.Digit = d;
        bm.Enter = 1'b1;
        tick();
        bm.Enter = 1'b0;
    endtask

    task automatic enter_code(input logic [23:0] code);
        for (int i = 0; i < 6; i++) enter_m(code[23-4*i -: 4]);
    endtask

    task automatic enter_i(input logic [3:0] d);
        bi.Digit = d;
        bi.Enter = 1'b1;
        tick();
        bi.Enter = 1'b0;
    endtask

    task automatic pulse_relock();
        bm.Relock = 1'b1;
        tick();
        bm.Relock = 1'b0;
    endtask

    task automatic pulse_program();
        bm.Program = 1'b1;
        tick();
        bm.Program = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bm.Digit = '0; bm.Enter = 1'b0; bm.Program = 1'b0; bm.Relock = 1'b0;
        bi.Digit = '0; bi.Enter = 1'b0; bi.Program = 1'b0; bi.Relock = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        chk("rst_open",  32'(bm.Open), 32'd0);
        chk("rst_alarm", 32'(bm.Alarm), 32'd0);
        chk("rst_state", 32'(bm.StateOut), 32'd0);
        chk("rst_dcnt",  32'(bm.DigitCount), 32'd0);
        chk("rst_fcnt",  32'(bm.FailCount), 32'd0);

        // Test 1: default code opens one cycle after the 6th Enter
        for (int i = 0; i < 5; i++) enter_m((24'h110010 >> (20 - 4*i)) & 4'hF);
        chk("t1_dcnt5", 32'(bm.DigitCount), 32'd5);
        chk("t1_closed5", 32'(bm.Open), 32'd0);
        enter_m(4'h0);
        chk("t1_open",  32'(bm.Open), 32'd1);
        chk("t1_state", 32'(bm.StateOut), 32'd1);
        chk("t1_fcnt",  32'(bm.FailCount), 32'd0);
        enter_m(4'h1);
        chk("t1_enter_ign", 32'(bm.DigitCount), 32'd0);
        pulse_relock();
        chk("t1_relock", 32'(bm.StateOut), 32'd0);
        chk("t1_relock_open", 32'(bm.Open), 32'd0);

        // Test 2: one wrong digit, all six absorbed
        enter_code(24'h100010);
        chk("t2_open",  32'(bm.Open), 32'd0);
        chk("t2_dcnt",  32'(bm.DigitCount), 32'd0);
        chk("t2_fcnt",  32'(bm.FailCount), 32'd1);
        enter_code(24'h110010);
        chk("t2_reopen", 32'(bm.Open), 32'd1);
        chk("t2_fclr",   32'(bm.FailCount), 32'd0);
        pulse_relock();

        // Test 3: three misses trigger a 1000-cycle lockout
        enter_code(24'h000000);
        enter_code(24'h111111);
        chk("t3_fcnt2", 32'(bm.FailCount), 32'd2);
        chk("t3_alarm0", 32'(bm.Alarm), 32'd0);
        enter_code(24'h110011);
        chk("t3_alarm", 32'(bm.Alarm), 32'd1);
        chk("t3_state", 32'(bm.StateOut), 32'd3);
        chk("t3_fmax",  32'(bm.FailCount), 32'd3);
        for (int c = 0; c < 999; c++) begin
            bm.Digit  = 4'h1;
            bm.Enter  = c[0];
            bm.Relock = c[1];
            tick();
        end
        bm.Enter = 1'b0; bm.Relock = 1'b0;
        chk("t3_still_lock", 32'(bm.StateOut), 32'd3);
        chk("t3_lock_dcnt",  32'(bm.DigitCount), 32'd0);
        tick();
        chk("t3_unlock", 32'(bm.StateOut), 32'd0);
        chk("t3_alarm_off", 32'(bm.Alarm), 32'd0);
        chk("t3_fcnt_clr", 32'(bm.FailCount), 32'd0);

        // Test 4: re-program the code while open
        enter_code(24'h110010);
        pulse_program();
        chk("t4_prog", 32'(bm.StateOut), 32'd2);
        chk("t4_prog_open", 32'(bm.Open), 32'd0);
        enter_code(24'h987654);
        chk("t4_commit", 32'(bm.StateOut), 32'd1);
        pulse_relock();
        enter_code(24'h110010);
        chk("t4_old_code", 32'(bm.Open), 32'd0);
        chk("t4_old_fcnt", 32'(bm.FailCount), 32'd1);
        enter_code(24'h987654);
        chk("t4_new_code", 32'(bm.Open), 32'd1);

        // Test 5: Relock with Enter aborts programming; then async reset mid-entry
        pulse_program();
        enter_m(4'h1); enter_m(4'h2); enter_m(4'h3);
        chk("t5_prog_dcnt", 32'(bm.DigitCount), 32'd3);
        bm.Digit = 4'h4; bm.Enter = 1'b1; bm.Relock = 1'b1;
        tick();
        bm.Enter = 1'b0; bm.Relock = 1'b0;
        chk("t5_abort", 32'(bm.StateOut), 32'd0);
        chk("t5_abort_dcnt", 32'(bm.DigitCount), 32'd0);
        enter_code(24'h987654);
        chk("t5_kept_code", 32'(bm.Open), 32'd1);
        pulse_relock();
        enter_m(4'h9); enter_m(4'h8);
        for (int c = 0; c < 60; c++) tick();
        chk("t5_no_timeout", 32'(bm.DigitCount), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_dcnt", 32'(bm.DigitCount), 32'd0);
        chk("t5_rst_open", 32'(bm.Open), 32'd0);
        rst_n = 1'b1;
        tick();
        enter_code(24'h110010);
        chk("t5_default_back", 32'(bm.Open), 32'd1);

        // Test 6: idle timeout discards a partial entry after 50 quiet cycles
        enter_i(4'h1); enter_i(4'h1);
        chk("t6_dcnt2", 32'(bi.DigitCount), 32'd2);
        for (int c = 0; c < 49; c++) tick();
        chk("t6_before", 32'(bi.DigitCount), 32'd2);
        tick();
        chk("t6_timeout", 32'(bi.DigitCount), 32'd0);
        chk("t6_fcnt", 32'(bi.FailCount), 32'd0);
        enter_code(24'h000000);
        for (int i = 0; i < 6; i++) enter_i((24'h110010 >> (20 - 4*i)) & 4'hF);
        chk("t6_open_after", 32'(bi.Open), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
